// File: rtl/acc_core_pkg.sv
// Shared opcode and FSM state encodings for the acc_core accumulator processor.
package acc_core_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_LDI  = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_SLL  = 4'h9;
    localparam logic [3:0] OP_SRL  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_BZ   = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

endpackage

// File: rtl/acc_core_if.sv
// Loader/status bundle of acc_core: the board loader is master, the core is slave.
interface acc_core_if #(
    parameter int DW = 8,
    parameter int AW = 8,
    parameter int MW = 4
) ();
    localparam int IW = 4 + MW;

    logic          start;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [IW-1:0] prog_data;
    logic [DW-1:0] acc_out;
    logic [AW-1:0] pc_out;
    logic          busy;
    logic          halted;

    modport master (
        output start, prog_we, prog_addr, prog_data,
        input  acc_out, pc_out, busy, halted
    );

    modport slave (
        input  start, prog_we, prog_addr, prog_data,
        output acc_out, pc_out, busy, halted
    );
endinterface

// File: rtl/acc_core_alu.sv
// Combinational accumulator datapath. Opcode 5 subtracts only when ACC_CORE_SUB_EN is defined.
module acc_core_alu
    import acc_core_pkg::*;
#(
    parameter int DW = 8,
    parameter int MW = 4
) (
    input  logic [3:0]    opcode,
    input  logic [DW-1:0] acc,
    input  logic [DW-1:0] dmem_data,
    input  logic [MW-1:0] operand,
    output logic [DW-1:0] acc_next,
    output logic          acc_we,
    output logic          zero
);

    always_comb begin
        acc_next = acc;
        acc_we   = 1'b1;
        case (opcode)
            OP_LD:   acc_next = dmem_data;
            OP_LDI:  acc_next = DW'(operand);
            OP_ADD:  acc_next = acc + dmem_data;
`ifdef ACC_CORE_SUB_EN
            OP_SUB:  acc_next = acc - dmem_data;
`else
            OP_SUB:  acc_we = 1'b0;
`endif
            OP_AND:  acc_next = acc & dmem_data;
            OP_OR:   acc_next = acc | dmem_data;
            OP_XOR:  acc_next = acc ^ dmem_data;
            OP_SLL:  acc_next = {acc[DW-2:0], 1'b0};
            OP_SRL:  acc_next = {1'b0, acc[DW-1:1]};
            default: acc_we = 1'b0;
        endcase
    end

    assign zero = (acc_next == '0);

endmodule

// File: rtl/acc_core.sv
// acc_core top: run/halt FSM, program counter, program memory and data memory.
// Build with ACC_CORE_SUB_EN defined to enable the SUB opcode.
module acc_core
    import acc_core_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 8,
    parameter int MW = 4
) (
    input  logic       clk,
    input  logic       rst,
    acc_core_if.slave  bus
);
    localparam int IW     = 4 + MW;
    localparam int PDEPTH = 1 << AW;
    localparam int DDEPTH = 1 << MW;

    logic [IW-1:0] prog_mem [PDEPTH];
    logic [DW-1:0] dmem_reg [DDEPTH];

    logic [1:0]    state_reg, state_next;
    logic [AW-1:0] pc_reg, pc_next;
    logic [DW-1:0] acc_reg;
    logic          z_reg;
    logic [IW-1:0] ir_reg;

    logic [3:0]    opcode;
    logic [MW-1:0] operand;
    logic [DW-1:0] dmem_data;
    logic [DW-1:0] alu_acc;
    logic          alu_we;
    logic          alu_zero;
    logic          stopped;
    logic          in_exec;

    assign opcode    = ir_reg[IW-1:MW];
    assign operand   = ir_reg[MW-1:0];
    assign dmem_data = dmem_reg[operand];
    assign stopped   = (state_reg == ST_IDLE) || (state_reg == ST_HALT);
    assign in_exec   = (state_reg == ST_EXEC);

    acc_core_alu #(.DW(DW), .MW(MW)) u_alu (
        .opcode    (opcode),
        .acc       (acc_reg),
        .dmem_data (dmem_data),
        .operand   (operand),
        .acc_next  (alu_acc),
        .acc_we    (alu_we),
        .zero      (alu_zero)
    );

    // Program memory is a plain RAM: never reset, written only while stopped.
    always_ff @(posedge clk) begin
        if (bus.prog_we && stopped)
            prog_mem[bus.prog_addr] <= bus.prog_data;
    end

    always_ff @(posedge clk) begin
        if (state_reg == ST_FETCH)
            ir_reg <= prog_mem[pc_reg];
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        case (state_reg)
            ST_FETCH: state_next = ST_EXEC;
            ST_EXEC: begin
                state_next = (opcode == OP_HALT) ? ST_HALT : ST_FETCH;
                if (opcode == OP_JMP || (opcode == OP_BZ && z_reg))
                    pc_next = AW'(dmem_data);
                else if (opcode != OP_HALT)
                    pc_next = pc_reg + AW'(1);
            end
            default: begin
                if (bus.start) begin
                    state_next = ST_FETCH;
                    pc_next    = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            pc_reg    <= '0;
            acc_reg   <= '0;
            z_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            if (in_exec && alu_we) begin
                acc_reg <= alu_acc;
                z_reg   <= alu_zero;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DDEPTH; i++)
                dmem_reg[i] <= '0;
        end else if (in_exec && opcode == OP_ST) begin
            dmem_reg[operand] <= acc_reg;
        end
    end

    assign bus.acc_out = acc_reg;
    assign bus.pc_out  = pc_reg;
    assign bus.busy    = (state_reg == ST_FETCH) || in_exec;
    assign bus.halted  = (state_reg == ST_HALT);

endmodule

// File: tb/tb_acc_core.sv
// Directed bench for acc_core: each run's expected outcome is queued at start and checked at halt.
module tb_acc_core;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int MW = 4;
    localparam int IW = 4 + MW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    acc_core_if #(.DW(DW), .AW(AW), .MW(MW)) bus ();

    acc_core #(.DW(DW), .AW(AW), .MW(MW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [DW-1:0] acc;
        logic [AW-1:0] pc;
        logic          z;
        int            cycles;
        int            start_cyc;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    logic [IW-1:0] pbuf[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic load(input logic [AW-1:0] addr, input logic [IW-1:0] data);
        @(negedge clk);
        bus.prog_we   = 1'b1;
        bus.prog_addr = addr;
        bus.prog_data = data;
        @(posedge clk);
        #1 bus.prog_we = 1'b0;
    endtask

    task automatic load_buf();
        foreach (pbuf[i]) load(AW'(i), pbuf[i]);
    endtask

    task automatic start_run(input int n, input logic [DW-1:0] ea,
                             input logic [AW-1:0] ep, input logic ez);
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        e.acc = ea; e.pc = ep; e.z = ez; e.cycles = 2 * n; e.start_cyc = cyc_cnt;
        sb.push_back(e);
        check("busy_after_start", 32'(bus.busy), 32'd1);
    endtask

    task automatic finish_run(input string tag);
        exp_t e;
        int guard;
        guard = 0;
        while (!bus.halted && guard < 1000) begin
            @(posedge clk);
            #1 guard++;
        end
        e = sb.pop_front();
        check({tag, "_cycles"}, 32'(cyc_cnt - e.start_cyc), 32'(e.cycles));
        check({tag, "_halted"}, 32'(bus.halted), 32'd1);
        check({tag, "_busy"},   32'(bus.busy), 32'd0);
        check({tag, "_acc"},    32'(bus.acc_out), 32'(e.acc));
        check({tag, "_pc"},     32'(bus.pc_out), 32'(e.pc));
        check({tag, "_z"},      32'(dut.z_reg), 32'(e.z));
        $display("run %s: acc=%0h pc=%0h z=%0b cycles=%0d", tag, bus.acc_out, bus.pc_out,
                 dut.z_reg, cyc_cnt - e.start_cyc);
    endtask

    task automatic run(input string tag, input int n, input logic [DW-1:0] ea,
                       input logic [AW-1:0] ep, input logic ez);
        start_run(n, ea, ep, ez);
        finish_run(tag);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.prog_we = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_acc", 32'(bus.acc_out), 32'd0);
        check("rst_pc", 32'(bus.pc_out), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_halted", 32'(bus.halted), 32'd0);
        @(negedge clk) rst = 1'b0;

        pbuf = '{8'h25, 8'h32, 8'h42, 8'hF0};
        load_buf();
        run("basic", 4, 8'h0A, 8'd3, 1'b0);
        check("basic_dmem2", 32'(dut.dmem_reg[2]), 32'h05);

        pbuf = '{8'h26, 8'h31, 8'h20, 8'hC1, 8'h29, 8'hF0, 8'h27, 8'hF0};
        load_buf();
        run("bz_taken", 6, 8'h07, 8'd7, 1'b0);
        load(8'd2, 8'h21);
        run("bz_not_taken", 6, 8'h09, 8'd5, 1'b0);

        pbuf = '{8'h23, 8'h30, 8'h50, 8'hF0};
        load_buf();
`ifdef ACC_CORE_SUB_EN
        run("sub", 4, 8'h00, 8'd3, 1'b1);
`else
        run("sub_nop", 4, 8'h03, 8'd3, 1'b0);
`endif

        pbuf = '{8'h2F, 8'h90, 8'h90, 8'h90, 8'h90, 8'hF0};
        load_buf();
        run("sll", 6, 8'hF0, 8'd5, 1'b0);
        pbuf = '{8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'hF0};
        load_buf();
        run("srl", 5, 8'h0F, 8'd4, 1'b0);

        for (int i = 0; i < 256; i++) load(AW'(i), (i == 1) ? 8'hF0 : 8'h00);
        run("nop_fill", 2, 8'h0F, 8'd1, 1'b0);

        pbuf = '{8'h2F, 8'h33, 8'h90, 8'h90, 8'h90, 8'h90, 8'h73, 8'h34, 8'h20, 8'hF0};
        load_buf();
        run("wrap_setup", 10, 8'h00, 8'd9, 1'b1);
        check("wrap_dmem4", 32'(dut.dmem_reg[4]), 32'hFF);
        load(8'd0, 8'hC4);
        load(8'd1, 8'hF0);
        load(8'd255, 8'h21);
        start_run(4, 8'h01, 8'd1, 1'b0);
        repeat (2) @(posedge clk);
        #1 check("wrap_pc255", 32'(bus.pc_out), 32'd255);
        repeat (2) @(posedge clk);
        #1 check("wrap_pc0", 32'(bus.pc_out), 32'd0);
        finish_run("wrap");

        pbuf = '{8'h25, 8'h32, 8'h42, 8'hF0};
        load_buf();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        bus.prog_we = 1'b1;
        bus.prog_addr = 8'd0;
        bus.prog_data = 8'hF0;
        @(posedge clk);
        #1 bus.prog_we = 1'b0;
        check("mid_in_exec", 32'(dut.state_reg), 32'(acc_core_pkg::ST_EXEC));
        #2 rst = 1'b1;
        #1;
        check("mid_rst_acc", 32'(bus.acc_out), 32'd0);
        check("mid_rst_pc", 32'(bus.pc_out), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_halted", 32'(bus.halted), 32'd0);
        check("mid_rst_z", 32'(dut.z_reg), 32'd0);
        check("mid_rst_dmem4", 32'(dut.dmem_reg[4]), 32'd0);
        $display("midrun reset: acc=%0h pc=%0h busy=%0b", bus.acc_out, bus.pc_out, bus.busy);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        run("rerun", 4, 8'h0A, 8'd3, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
